booth4_sequencer: RTL and testbench

Front-end and back-end sequencer for the radix-4 Booth multiplier (`booth4`).
- Accepts a signed operand pair over a valid/ready handshake.
- Drives the multiplier's start pulse and its shared 8-bit input bus, placing M then Q in the required cycles.
- Captures the two product bytes returned on the multiplier's shared output bus.
- Presents the 16-bit signed product over a valid/ready handshake, with a watchdog against a stalled multiplier.

---
 rtl/booth4_seq_pkg.sv | 26 ++
 rtl/counter_nbits.sv | 25 ++
 rtl/booth4_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_booth4_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/booth4_seq_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier sequencer.
package booth4_seq_pkg;

  // Operand and product widths.
  localparam int OPW   = 8;
  localparam int PRODW = 16;

  // Default bus placement offsets (cycles after the mul_enable cycle)
  // and default watchdog limit in WAIT cycles.
  localparam int M_OFFSET_DEF = 1;
  localparam int Q_OFFSET_DEF = 2;
  localparam int TIMEOUT_DEF  = 63;

  // Sequencer states. ST_CAP_HI is an alias of the WAIT capture cycle;
  // the FSM merges it with ST_WAIT and never enters it on its own.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_FEED   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_CAP_HI = 3'd4,
    ST_CAP_LO = 3'd5,
    ST_HOLD   = 3'd6
  } seq_state_t;

endpackage

// File: rtl/counter_nbits.sv
// Generic up-counter with synchronous clear and count enable.
module counter_nbits #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Count register: clear has priority over enable, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/booth4_sequencer.sv
// Operand feeder and result collector for the radix-4 Booth multiplier.
// Accepts an operand pair, pulses mul_enable, places M and Q on the shared
// input bus at fixed offsets, captures the high then low product byte and
// holds the product until downstream takes it. A watchdog aborts a stalled
// multiplier with a zero product flagged by out_timeout.
module booth4_sequencer
  import booth4_seq_pkg::*;
#(
  parameter int M_OFFSET = M_OFFSET_DEF,
  parameter int Q_OFFSET = Q_OFFSET_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_m,
  input  logic [OPW-1:0]   in_q,
  output logic             mul_enable,
  output logic [OPW-1:0]   mul_inbus,
  input  logic             mul_done,
  input  logic [OPW-1:0]   mul_outbus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PRODW-1:0] out_product,
  output logic             out_timeout
);

  // Offsets and watchdog limit as 8-bit compare constants. The abort fires
  // in the WAIT cycle whose pre-increment count is TIMEOUT-1, i.e. after
  // exactly TIMEOUT WAIT cycles.
  localparam logic [7:0] M_OFF_C  = 8'(M_OFFSET);
  localparam logic [7:0] Q_OFF_C  = 8'(Q_OFFSET);
  localparam logic [7:0] WD_LIM_C = 8'(TIMEOUT - 1);

  seq_state_t state_r;
  seq_state_t state_next_s;

  logic [OPW-1:0]   m_r;
  logic [OPW-1:0]   q_r;
  logic [PRODW-1:0] product_r;
  logic             timeout_r;
  logic             in_ready_r;
  logic             mul_enable_r;
  logic [OPW-1:0]   mul_inbus_r;
  logic             out_valid_r;

  logic       latch_s;
  logic       cap_hi_s;
  logic       cap_lo_s;
  logic       abort_s;
  logic       phase_clr_s;
  logic       phase_en_s;
  logic       wd_clr_s;
  logic       wd_en_s;
  logic [7:0] phase_cnt_s;
  logic [7:0] phase_s;
  logic [7:0] phase_next_s;
  logic [7:0] wd_cnt_s;
  logic [7:0] inbus_next_s;

  // Phase counter: cleared in START, counts FEED cycles.
  counter_nbits #(.WIDTH(8)) u_phase_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (phase_clr_s),
    .en    (phase_en_s),
    .count (phase_cnt_s)
  );

  // Watchdog counter: counts WAIT cycles, cleared everywhere else.
  counter_nbits #(.WIDTH(8)) u_wd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wd_clr_s),
    .en    (wd_en_s),
    .count (wd_cnt_s)
  );

  // The counter starts at zero in the first FEED cycle, which is phase 1.
  assign phase_s = phase_cnt_s + 8'd1;

  // Next-state and control strobes for the sequencer FSM.
  always_comb begin
    state_next_s = state_r;
    latch_s      = 1'b0;
    cap_hi_s     = 1'b0;
    cap_lo_s     = 1'b0;
    abort_s      = 1'b0;
    phase_clr_s  = 1'b1;
    phase_en_s   = 1'b0;
    wd_clr_s     = 1'b1;
    wd_en_s      = 1'b0;
    phase_next_s = 8'd0;
    case (state_r)
      ST_IDLE: begin
        // in_ready_r gates acceptance so the cycle right after reset
        // release (in_ready still low) cannot take an operand.
        if (in_valid && in_ready_r) begin
          latch_s      = 1'b1;
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        phase_clr_s  = 1'b1;
        phase_next_s = 8'd1;
        state_next_s = ST_FEED;
      end
      ST_FEED: begin
        phase_clr_s = 1'b0;
        phase_en_s  = 1'b1;
        if (phase_s == Q_OFF_C) begin
          state_next_s = ST_WAIT;
        end else begin
          phase_next_s = phase_s + 8'd1;
          state_next_s = ST_FEED;
        end
      end
      ST_WAIT, ST_CAP_HI: begin
        wd_clr_s = 1'b0;
        wd_en_s  = 1'b1;
        // done is checked first so it wins on the watchdog boundary cycle
        if (mul_done) begin
          cap_hi_s     = 1'b1;
          state_next_s = ST_CAP_LO;
        end else if (wd_cnt_s == WD_LIM_C) begin
          abort_s      = 1'b1;
          state_next_s = ST_HOLD;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_CAP_LO: begin
        cap_lo_s     = 1'b1;
        state_next_s = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Operand bus value for the coming cycle, chosen by the coming phase.
  always_comb begin
    inbus_next_s = 8'h00;
    if (state_next_s == ST_FEED) begin
      if (phase_next_s == M_OFF_C) begin
        inbus_next_s = m_r;
      end else if (phase_next_s == Q_OFF_C) begin
        inbus_next_s = q_r;
      end else begin
        inbus_next_s = 8'h00;
      end
    end else begin
      inbus_next_s = 8'h00;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered handshake and multiplier-drive outputs, decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r   <= 1'b0;
      mul_enable_r <= 1'b0;
      mul_inbus_r  <= 8'h00;
      out_valid_r  <= 1'b0;
    end else begin
      in_ready_r   <= (state_next_s == ST_IDLE);
      mul_enable_r <= (state_next_s == ST_START);
      mul_inbus_r  <= inbus_next_s;
      out_valid_r  <= (state_next_s == ST_HOLD);
    end
  end

  // Operand latches, loaded on the accept handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r <= 8'h00;
      q_r <= 8'h00;
    end else if (latch_s) begin
      m_r <= in_m;
      q_r <= in_q;
    end else begin
      m_r <= m_r;
      q_r <= q_r;
    end
  end

  // Product capture: high byte on done, low byte one cycle later, or zero
  // with the timeout flag on a watchdog abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_r <= 16'h0000;
      timeout_r <= 1'b0;
    end else if (cap_hi_s) begin
      product_r[15:8] <= mul_outbus;
    end else if (abort_s) begin
      product_r <= 16'h0000;
      timeout_r <= 1'b1;
    end else if (cap_lo_s) begin
      product_r[7:0] <= mul_outbus;
      timeout_r      <= 1'b0;
    end else begin
      product_r <= product_r;
      timeout_r <= timeout_r;
    end
  end

  assign in_ready    = in_ready_r;
  assign mul_enable  = mul_enable_r;
  assign mul_inbus   = mul_inbus_r;
  assign out_valid   = out_valid_r;
  assign out_product = product_r;
  assign out_timeout = timeout_r;

endmodule

// File: tb/tb_booth4_sequencer.sv
// Directed, table-driven bench for booth4_sequencer with a behavioural
// Booth multiplier model driven from the bench.
module tb_booth4_sequencer;

  localparam int MO = 1;
  localparam int QO = 2;
  localparam int TO = 63;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_m;
  logic [7:0]  in_q;
  logic        mul_enable;
  logic [7:0]  mul_inbus;
  logic        mul_done;
  logic [7:0]  mul_outbus;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;
  logic        out_timeout;

  int checks;
  int failures;

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    int          d;         // WAIT cycles before done; -1 = never done
    int          hold_cyc;  // cycles out_ready is held low in HOLD
    logic [15:0] exp_prod;
    logic        exp_tmo;
  } vec_t;

  vec_t vecs [6];
  vec_t rvec;

  booth4_sequencer #(
    .M_OFFSET (MO),
    .Q_OFFSET (QO),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_m        (in_m),
    .in_q        (in_q),
    .mul_enable  (mul_enable),
    .mul_inbus   (mul_inbus),
    .mul_done    (mul_done),
    .mul_outbus  (mul_outbus),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_timeout (out_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One full operation: handshake, multiplier model, result, hold, release.
  task automatic run_op(input vec_t v, input string tag);
    int n;
    int lat;
    int exp_lat;
    int bad_en;
    int bad_bus;
    int bad_hold;
    logic [7:0] cap_m;
    logic [7:0] cap_q;
    logic signed [7:0]  sm;
    logic signed [7:0]  sq;
    logic signed [15:0] mprod;
    logic [15:0] held_prod;
    logic        held_tmo;

    lat = -1; bad_en = 0; bad_bus = 0; bad_hold = 0;
    cap_m = 8'h00; cap_q = 8'h00;
    @(negedge clk);
    in_m = v.m; in_q = v.q; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept_ready"}, {31'd0, in_ready}, 32'd1);

    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        lat = k;
        break;
      end
      if (mul_enable !== (k == 0)) bad_en++;
      if (k == MO) cap_m = mul_inbus;
      else if (k == QO) cap_q = mul_inbus;
      else if (mul_inbus !== 8'h00) bad_bus++;
      sm = cap_m; sq = cap_q;
      mprod = sm * sq;
      if (v.d >= 0 && k == QO + 1 + v.d) begin
        mul_done = 1'b1; mul_outbus = mprod[15:8];
      end else if (v.d >= 0 && k == QO + 2 + v.d) begin
        mul_done = 1'b0; mul_outbus = mprod[7:0];
      end else begin
        mul_done = 1'b0; mul_outbus = 8'h5A;
      end
    end
    mul_done = 1'b0;
    exp_lat = (v.d >= 0) ? (QO + 3 + v.d) : (QO + 1 + TO);
    check({tag, "_enable_pulse"}, bad_en, 32'd0);
    check({tag, "_bus_idle_zero"}, bad_bus, 32'd0);
    check({tag, "_bus_m"}, {24'd0, cap_m}, {24'd0, v.m});
    check({tag, "_bus_q"}, {24'd0, cap_q}, {24'd0, v.q});
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_product"}, {16'd0, out_product}, {16'd0, v.exp_prod});
    check({tag, "_timeout"}, {31'd0, out_timeout}, {31'd0, v.exp_tmo});

    held_prod = out_product;
    held_tmo  = out_timeout;
    if (v.hold_cyc > 0) begin
      in_valid = 1'b1; in_m = 8'h11; in_q = 8'h22;
      for (int h = 0; h < v.hold_cyc; h++) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_product !== held_prod || out_timeout !== held_tmo ||
            in_ready !== 1'b0 || mul_enable !== 1'b0) bad_hold++;
      end
      check({tag, "_hold_stable"}, bad_hold, 32'd0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int bad;
    checks = 0; failures = 0;

    vecs[0] = '{m: 8'd3,   q: 8'd5,   d: 0,  hold_cyc: 0,  exp_prod: 16'h000F, exp_tmo: 1'b0};
    vecs[1] = '{m: 8'hFC,  q: 8'd6,   d: 3,  hold_cyc: 0,  exp_prod: 16'hFFE8, exp_tmo: 1'b0};
    vecs[2] = '{m: 8'h80,  q: 8'h80,  d: 1,  hold_cyc: 0,  exp_prod: 16'h4000, exp_tmo: 1'b0};
    vecs[3] = '{m: 8'd7,   q: 8'd7,   d: 2,  hold_cyc: 10, exp_prod: 16'h0031, exp_tmo: 1'b0};
    vecs[4] = '{m: 8'h12,  q: 8'h34,  d: -1, hold_cyc: 0,  exp_prod: 16'h0000, exp_tmo: 1'b1};
    vecs[5] = '{m: 8'd9,   q: 8'hFF,  d: 62, hold_cyc: 0,  exp_prod: 16'hFFF7, exp_tmo: 1'b0};
    rvec    = '{m: 8'd2,   q: 8'hFD,  d: 1,  hold_cyc: 0,  exp_prod: 16'hFFFA, exp_tmo: 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_m = 8'h00; in_q = 8'h00;
    mul_done = 1'b0; mul_outbus = 8'h00; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_outputs", {14'd0, mul_enable, mul_inbus, out_valid, out_product[7:0]}, 32'd0);
    check("rst_prod_tmo", {15'd0, out_product, out_timeout}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i], $sformatf("v%0d", i));
    end

    // A done left high in IDLE must not produce a result.
    mul_done = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    mul_done = 1'b0;
    check("idle_done_ignored", bad, 32'd0);

    // Reset asserted during FEED aborts the operation immediately.
    in_m = 8'h44; in_q = 8'h55; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_bus_m", {24'd0, mul_inbus}, 32'h44);
    rst_n = 1'b0;
    #1;
    check("midrst_drive", {23'd0, mul_enable, mul_inbus}, 32'd0);
    check("midrst_out", {14'd0, out_valid, out_timeout, out_product}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || mul_enable !== 1'b0 || mul_inbus !== 8'h00) bad++;
    end
    check("postrst_quiet", bad, 32'd0);
    run_op(rvec, "rst_next");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
